// File: rtl/bp_be_fpu_recode_sequencer.sv
// Shares one combinational FP recode unit across up to three FPU source operands, one per cycle.
// Optional BP_BE_FPU_RECODE_FLUSH_EN adds flush_i to abandon an in-flight sequence.
module bp_be_fpu_recode_sequencer #(
  parameter int unsigned dword_width_p  = 64,
  parameter int unsigned dp_rec_width_p = 65,
  parameter int unsigned num_ops_p      = 3
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
`ifdef BP_BE_FPU_RECODE_FLUSH_EN
  input  logic                                      flush_i,
`endif
  input  logic                                      v_i,
  output logic                                      ready_o,
  input  logic                                      ipr_i,
  input  logic [1:0]                                num_src_i,
  input  logic [num_ops_p-1:0][dword_width_p-1:0]   rs_i,
  output logic [dword_width_p-1:0]                  rec_fp_o,
  output logic                                      rec_ipr_o,
  input  logic [dword_width_p-1:0]                  rec_fp_i,
  input  logic [dp_rec_width_p-1:0]                 rec_i,
  input  logic                                      rec_nan_i,
  input  logic                                      rec_snan_i,
  input  logic                                      rec_sub_i,
  output logic                                      v_o,
  input  logic                                      yumi_i,
  output logic [num_ops_p-1:0][dword_width_p-1:0]   fp_o,
  output logic [num_ops_p-1:0][dp_rec_width_p-1:0]  rec_o,
  output logic [num_ops_p-1:0]                      nan_o,
  output logic [num_ops_p-1:0]                      snan_o,
  output logic [num_ops_p-1:0]                      sub_o,
  output logic                                      any_snan_o
);

  localparam int unsigned idx_width_lp = 2;

  typedef enum logic [1:0] {
    e_idle   = 2'd0,
    e_recode = 2'd1,
    e_done   = 2'd2
  } state_e;

  state_e                                     state_q, state_d;
  logic [idx_width_lp-1:0]                    idx_q, idx_d;
  logic [idx_width_lp-1:0]                    num_q, num_d;
  logic                                       ipr_q, ipr_d;
  logic [num_ops_p-1:0][dword_width_p-1:0]    ops_q, ops_d;
  logic [num_ops_p-1:0][dword_width_p-1:0]    fp_q, fp_d;
  logic [num_ops_p-1:0][dp_rec_width_p-1:0]   rec_q, rec_d;
  logic [num_ops_p-1:0]                       nan_q, nan_d;
  logic [num_ops_p-1:0]                       snan_q, snan_d;
  logic [num_ops_p-1:0]                       sub_q, sub_d;
  logic                                       flush_w;
  logic                                       accept_w;
  logic [num_ops_p-1:0]                       valid_mask_w;

`ifdef BP_BE_FPU_RECODE_FLUSH_EN
  assign flush_w = flush_i;
`else
  assign flush_w = 1'b0;
`endif

  // Next-state, slot capture and handshake
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    ipr_d     = ipr_q;
    ops_d     = ops_q;
    fp_d      = fp_q;
    rec_d     = rec_q;
    nan_d     = nan_q;
    snan_d    = snan_q;
    sub_d     = sub_q;
    ready_o   = 1'b0;
    rec_fp_o  = '0;
    rec_ipr_o = 1'b0;
    accept_w  = 1'b0;

    case (state_q)
      e_idle: ready_o = 1'b1;
      e_recode: begin
        rec_fp_o       = ops_q[idx_q];
        rec_ipr_o      = ipr_q;
        fp_d[idx_q]    = rec_fp_i;
        rec_d[idx_q]   = rec_i;
        nan_d[idx_q]   = rec_nan_i;
        snan_d[idx_q]  = rec_snan_i;
        sub_d[idx_q]   = rec_sub_i;
        if (idx_q == num_q - 2'd1) state_d = e_done;
        else                       idx_d   = idx_q + 2'd1;
      end
      e_done: begin
        ready_o = yumi_i;
        if (yumi_i) state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase

    if (flush_w) ready_o = 1'b0;
    accept_w = v_i & ready_o;

    if (accept_w) begin
      ops_d   = rs_i;
      ipr_d   = ipr_i;
      num_d   = num_src_i;
      fp_d    = '0;
      rec_d   = '0;
      nan_d   = '0;
      snan_d  = '0;
      sub_d   = '0;
      idx_d   = '0;
      state_d = (num_src_i != 2'd0) ? e_recode : e_done;
    end

    // Flush overrides any handshake in the same cycle
    if (flush_w) begin
      state_d = e_idle;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      idx_q   <= '0;
      num_q   <= '0;
      ipr_q   <= 1'b0;
      ops_q   <= '0;
      fp_q    <= '0;
      rec_q   <= '0;
      nan_q   <= '0;
      snan_q  <= '0;
      sub_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      ipr_q   <= ipr_d;
      ops_q   <= ops_d;
      fp_q    <= fp_d;
      rec_q   <= rec_d;
      nan_q   <= nan_d;
      snan_q  <= snan_d;
      sub_q   <= sub_d;
    end
  end

  // Only slots below the latched operand count contribute to any_snan_o
  assign valid_mask_w = num_ops_p'((4'd1 << num_q) - 4'd1);

  assign v_o        = (state_q == e_done);
  assign fp_o       = fp_q;
  assign rec_o      = rec_q;
  assign nan_o      = nan_q;
  assign snan_o     = snan_q;
  assign sub_o      = sub_q;
  assign any_snan_o = |(snan_q & valid_mask_w);

endmodule

// File: tb/tb_bp_be_fpu_recode_sequencer.sv
// Directed self-checking bench for bp_be_fpu_recode_sequencer with a behavioural recode unit.
`timescale 1ns/1ps
module tb_bp_be_fpu_recode_sequencer;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic              flush_i;
  logic              v_i, ready_o, ipr_i, yumi_i;
  logic [1:0]        num_src_i;
  logic [2:0][63:0]  rs_i;
  logic [63:0]       rec_fp_o, rec_fp_i;
  logic              rec_ipr_o;
  logic [64:0]       rec_i;
  logic              rec_nan_i, rec_snan_i, rec_sub_i;
  logic              v_o;
  logic [2:0][63:0]  fp_o;
  logic [2:0][64:0]  rec_o;
  logic [2:0]        nan_o, snan_o, sub_o;
  logic              any_snan_o;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  always #5 clk_i = ~clk_i;

  bp_be_fpu_recode_sequencer dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
`ifdef BP_BE_FPU_RECODE_FLUSH_EN
    .flush_i(flush_i),
`endif
    .v_i(v_i), .ready_o(ready_o), .ipr_i(ipr_i), .num_src_i(num_src_i), .rs_i(rs_i),
    .rec_fp_o(rec_fp_o), .rec_ipr_o(rec_ipr_o), .rec_fp_i(rec_fp_i), .rec_i(rec_i),
    .rec_nan_i(rec_nan_i), .rec_snan_i(rec_snan_i), .rec_sub_i(rec_sub_i),
    .v_o(v_o), .yumi_i(yumi_i), .fp_o(fp_o), .rec_o(rec_o),
    .nan_o(nan_o), .snan_o(snan_o), .sub_o(sub_o), .any_snan_o(any_snan_o)
  );

  // Stand-in recode unit: classifies and canonicalizes unboxed singles
  always_comb begin
    rec_fp_i   = rec_fp_o;
    rec_nan_i  = 1'b0;
    rec_snan_i = 1'b0;
    rec_sub_i  = 1'b0;
    if (rec_ipr_o) begin
      rec_nan_i  = (rec_fp_o[62:52] == 11'h7FF) && (rec_fp_o[51:0] != 52'd0);
      rec_snan_i = rec_nan_i && !rec_fp_o[51];
      rec_sub_i  = (rec_fp_o[62:52] == 11'h000) && (rec_fp_o[51:0] != 52'd0);
    end else if (rec_fp_o[63:32] != 32'hFFFFFFFF) begin
      rec_fp_i  = 64'hFFFFFFFF_7FC00000;
      rec_nan_i = 1'b1;
    end else begin
      rec_nan_i  = (rec_fp_o[30:23] == 8'hFF) && (rec_fp_o[22:0] != 23'd0);
      rec_snan_i = rec_nan_i && !rec_fp_o[22];
      rec_sub_i  = (rec_fp_o[30:23] == 8'h00) && (rec_fp_o[22:0] != 23'd0);
    end
    rec_i = {1'b0, rec_fp_i};
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request from IDLE; lat counts cycles from the accept cycle to v_o
  task automatic do_req(input logic ipr, input logic [1:0] n, input logic [2:0][63:0] rs);
    v_i = 1'b1; ipr_i = ipr; num_src_i = n; rs_i = rs;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    lat = 1;
    while (!v_o && lat < 20) begin
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  task automatic consume();
    yumi_i = 1'b1;
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
  endtask

  logic [2:0][63:0] rs;
  logic [2:0][63:0] bank;
  logic [63:0] vec [4];

  initial begin
    reset_n_i = 1'b0; flush_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
    ipr_i = 1'b0; num_src_i = 2'd0; rs_i = '0;
    #12;
    check("rst_v_o", 128'(v_o), 128'(1'b0));
    check("rst_ready", 128'(ready_o), 128'(1'b1));
    check("rst_any_snan", 128'(any_snan_o), 128'(1'b0));
    check("rst_fp_o", 128'(fp_o[0] | fp_o[1] | fp_o[2]), 128'd0);
    check("rst_rec_fp_o", 128'(rec_fp_o), 128'd0);
    @(negedge clk_i); reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    // Double, three operands: normal, sNaN, subnormal
    rs[0] = 64'h3FF0000000000000; rs[1] = 64'h7FF0000000000001; rs[2] = 64'h0000000000000001;
    do_req(1'b1, 2'd3, rs);
    check("dbl_lat", 128'(lat), 128'd4);
    check("dbl_nan", 128'(nan_o), 128'(3'b010));
    check("dbl_snan", 128'(snan_o), 128'(3'b010));
    check("dbl_sub", 128'(sub_o), 128'(3'b100));
    check("dbl_any_snan", 128'(any_snan_o), 128'(1'b1));
    check("dbl_fp1", 128'(fp_o[1]), 128'(64'h7FF0000000000001));
    check("dbl_rec2", 128'(rec_o[2]), 128'(65'h0_0000000000000001));
    check("dbl_ready", 128'(ready_o), 128'(1'b0));
    consume();
    check("dbl_back_idle", 128'({v_o, ready_o}), 128'(2'b01));

    // Single, two operands; second not NaN-boxed
    rs[0] = 64'hFFFFFFFF3F800000; rs[1] = 64'h000000003F800000; rs[2] = 64'h1234567812345678;
    do_req(1'b0, 2'd2, rs);
    check("sgl_lat", 128'(lat), 128'd3);
    check("sgl_fp0", 128'(fp_o[0]), 128'(64'hFFFFFFFF3F800000));
    check("sgl_fp1", 128'(fp_o[1]), 128'(64'hFFFFFFFF_7FC00000));
    check("sgl_nan", 128'(nan_o), 128'(3'b010));
    check("sgl_slot2", 128'({fp_o[2], nan_o[2], snan_o[2], sub_o[2]}), 128'd0);
    check("sgl_slot2_rec", 128'(rec_o[2]), 128'd0);
    check("sgl_any_snan", 128'(any_snan_o), 128'(1'b0));
    consume();

    // Zero operands
    rs[0] = 64'h7FF0000000000001; rs[1] = 64'h1; rs[2] = 64'h2;
    do_req(1'b1, 2'd0, rs);
    check("n0_lat", 128'(lat), 128'd1);
    check("n0_bank", 128'({fp_o, nan_o, snan_o, sub_o}), 128'd0);
    check("n0_any_snan", 128'(any_snan_o), 128'(1'b0));
    check("n0_rec_fp_o", 128'(rec_fp_o), 128'd0);
    consume();

    // Back-to-back with yumi_i and v_i held high, one operand each
    vec[0] = 64'h4000000000000000; vec[1] = 64'h4008000000000000;
    vec[2] = 64'hC010000000000000; vec[3] = 64'h3FE0000000000000;
    ipr_i = 1'b1; num_src_i = 2'd1; rs_i = '0; rs_i[0] = vec[0];
    v_i = 1'b1; yumi_i = 1'b1;
    @(posedge clk_i); #1;
    for (int k = 0; k < 3; k++) begin
      rs_i[0] = vec[k+1];
      check("b2b_recode_v_o", 128'(v_o), 128'(1'b0));
      @(posedge clk_i); #1;
      check("b2b_v_o", 128'(v_o), 128'(1'b1));
      check("b2b_ready", 128'(ready_o), 128'(1'b1));
      check("b2b_fp0", 128'(fp_o[0]), 128'(vec[k]));
      @(posedge clk_i); #1;
    end
    v_i = 1'b0; yumi_i = 1'b0;
    @(posedge clk_i); #1;
    check("b2b_last_fp0", 128'(fp_o[0]), 128'(vec[3]));

    // Backpressure: hold the bank for 5 cycles
    for (int k = 0; k < 5; k++) begin
      check("bp_v_o", 128'(v_o), 128'(1'b1));
      check("bp_ready", 128'(ready_o), 128'(1'b0));
      check("bp_fp0", 128'(fp_o[0]), 128'(vec[3]));
      @(posedge clk_i); #1;
    end
    yumi_i = 1'b1; #1;
    check("bp_ready_yumi", 128'(ready_o), 128'(1'b1));
    @(posedge clk_i); #1;
    yumi_i = 1'b0;
    check("bp_idle", 128'({v_o, ready_o}), 128'(2'b01));

    // Reset mid-RECODE at idx 1
    rs[0] = 64'h3FF0000000000000; rs[1] = 64'h7FF0000000000001; rs[2] = 64'h1;
    v_i = 1'b1; ipr_i = 1'b1; num_src_i = 2'd3; rs_i = rs;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    @(posedge clk_i); #1;
    check("mid_rec_fp_o", 128'(rec_fp_o), 128'(64'h7FF0000000000001));
    reset_n_i = 1'b0; #1;
    check("rst_mid_v_o", 128'(v_o), 128'(1'b0));
    check("rst_mid_ready", 128'(ready_o), 128'(1'b1));
    check("rst_mid_bank", 128'(fp_o[0] | fp_o[1] | fp_o[2]), 128'd0);
    @(negedge clk_i); reset_n_i = 1'b1;
    @(posedge clk_i); #1;

`ifdef BP_BE_FPU_RECODE_FLUSH_EN
    // Flush at the same point: back to IDLE, no v_o pulse
    v_i = 1'b1; ipr_i = 1'b1; num_src_i = 2'd3; rs_i = rs;
    @(posedge clk_i); #1;
    v_i = 1'b0;
    @(posedge clk_i); #1;
    flush_i = 1'b1; v_i = 1'b1; #1;
    check("flush_ready", 128'(ready_o), 128'(1'b0));
    @(posedge clk_i); #1;
    flush_i = 1'b0; v_i = 1'b0;
    check("flush_idle", 128'({v_o, ready_o}), 128'(2'b01));
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_i); #1;
      check("flush_no_v_o", 128'(v_o), 128'(1'b0));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
